// File: rtl/instr_cache_refill_ctrl.sv
// Instruction-cache refill engine.
//
// On a miss it issues one block-aligned burst request, collects B/4 32-bit read beats into a local
// buffer of 64-bit words, then streams the B/8 words to the cache set on consecutive cycles with
// ic_repl_grant_o high. Fetch is stalled from the miss cycle until the engine returns to idle.
//
// Ports
//   clk_i            clock
//   reset_i          synchronous reset, active-low
//   ic_miss_i        miss from the active cache set (sampled in idle only)
//   miss_addr_i      fetch PC that missed
//   mem_req_o        burst request valid to memory (registered)
//   mem_addr_o       block-aligned burst address (registered)
//   mem_req_ready_i  memory accepts the request
//   mem_rvalid_i     read beat valid
//   mem_rdata_i      read beat data, ascending addresses
//   ic_repl_grant_o  replacement grant to the cache set (registered)
//   rep_word_o       replacement word to the cache set (registered)
//   ic_stall_o       fetch stall (combinational)

module instr_cache_refill_ctrl #(
  parameter int unsigned B      = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              ic_repl_grant_o,
  output logic [63:0]       rep_word_o,
  output logic              ic_stall_o
);

  localparam int unsigned OffW     = $clog2(B);
  localparam int unsigned NumBeats = B / 4;
  localparam int unsigned NumWords = B / 8;
  localparam int unsigned BeatW    = $clog2(NumBeats);
  localparam int unsigned WordW    = $clog2(NumWords);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);
  localparam logic [WordW-1:0] LastWord = WordW'(NumWords - 1);
  localparam logic [BeatW-1:0] BeatOne  = BeatW'(1);
  localparam logic [WordW-1:0] WordOne  = WordW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFill,
    StStream,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                grant_q, grant_d;
  logic [63:0]         rep_word_q, rep_word_d;
  logic [BeatW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [WordW-1:0]    stream_cnt_q, stream_cnt_d;
  logic [63:0]         buf_q [NumWords];
  logic [63:0]         buf_d [NumWords];

  logic [WordW-1:0]    next_word;
  logic [WordW-1:0]    fill_word;

  // Offset bits of the miss PC are dropped by block alignment.
  logic                unused_miss_lsb;
  assign unused_miss_lsb = ^miss_addr_i[OffW-1:0];

  assign next_word = stream_cnt_q + WordOne;
  // Two beats per word: beat_cnt[0] picks the half, the rest picks the word.
  assign fill_word = beat_cnt_q[BeatW-1:1];

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    grant_d      = grant_q;
    rep_word_d   = rep_word_q;
    beat_cnt_d   = beat_cnt_q;
    stream_cnt_d = stream_cnt_q;
    buf_d        = buf_q;

    unique case (state_q)
      StIdle: begin
        if (ic_miss_i) begin
          mem_addr_d = {miss_addr_i[ADDR_W-1:OffW], {OffW{1'b0}}};
          mem_req_d  = 1'b1;
          state_d    = StReq;
        end
      end

      StReq: begin
        // Any beat presented alongside the handshake is ignored: memory answers later.
        if (mem_req_ready_i) begin
          mem_req_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = StFill;
        end
      end

      StFill: begin
        if (mem_rvalid_i) begin
          if (beat_cnt_q[0]) begin
            buf_d[fill_word][63:32] = mem_rdata_i;
          end else begin
            buf_d[fill_word][31:0]  = mem_rdata_i;
          end
          beat_cnt_d = beat_cnt_q + BeatOne;
          if (beat_cnt_q == LastBeat) begin
            // Word 0 was completed several beats ago, so it can be presented right away.
            state_d      = StStream;
            stream_cnt_d = '0;
            grant_d      = 1'b1;
            rep_word_d   = buf_q[0];
          end
        end
      end

      StStream: begin
        if (stream_cnt_q == LastWord) begin
          grant_d      = 1'b0;
          stream_cnt_d = '0;
          state_d      = StDone;
        end else begin
          stream_cnt_d = next_word;
          rep_word_d   = buf_q[next_word];
        end
      end

      StDone: begin
        // Gives the set one cycle to drop its miss after the tag write.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= StIdle;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      grant_q      <= 1'b0;
      rep_word_q   <= '0;
      beat_cnt_q   <= '0;
      stream_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      grant_q      <= grant_d;
      rep_word_q   <= rep_word_d;
      beat_cnt_q   <= beat_cnt_d;
      stream_cnt_q <= stream_cnt_d;
    end
  end

  // Data buffer carries no reset; a fresh refill overwrites every word before streaming.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  assign mem_req_o       = mem_req_q;
  assign mem_addr_o      = mem_addr_q;
  assign ic_repl_grant_o = grant_q;
  assign rep_word_o      = rep_word_q;
  assign ic_stall_o      = (state_q != StIdle) | ic_miss_i;

endmodule
